opb_register_bank_ppc2simulink: RTL

Parametrised successor to the single software-to-fabric register. Presents N_REGS 32-bit, byte-writable, readable registers to the PowerPC over OPB. Each register is a shadow that feeds the user-side output either immediately (auto-commit) or atomically for all registers at once when a commit is written to a control word. Single clock domain: the user logic runs on OPB_Clk.

---
 rtl/opb_regbank_pkg.sv | 13 +
 rtl/opb_slave_ack_fsm.sv | 64 ++++++
 rtl/opb_register_bank_ppc2simulink.sv | 107 ++++++++++
 3 files changed

// File: rtl/opb_regbank_pkg.sv
// opb_regbank_pkg: shared types and helpers for the OPB register bank.
package opb_regbank_pkg;
    typedef enum logic [1:0] {IDLE, ACK, HOLD} state_e;
    localparam int CTRL_COMMIT = 0;
    localparam int CTRL_AUTO   = 1;
    function automatic int ctrl_offset(input int n_regs);
        return n_regs;
    endfunction
    // OPB lane 0 (BE[0], DBus[0:7]) is the most significant register byte.
    function automatic logic [31:0] lane_mask(input logic [0:3] be);
        return {{8{be[0]}}, {8{be[1]}}, {8{be[2]}}, {8{be[3]}}};
    endfunction
endpackage

// File: rtl/opb_slave_ack_fsm.sv
// opb_slave_ack_fsm: OPB address decode, request latching and one-cycle ack timing.
module opb_slave_ack_fsm
    import opb_regbank_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR   = 32'h010B0000,
    parameter logic [31:0] C_HIGHADDR   = 32'h010B00FF,
    parameter int          C_OPB_AWIDTH = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [C_OPB_AWIDTH-1:0] abus_i,
    input  logic [0:3]              be_i,
    input  logic [31:0]             data_i,
    input  logic                    rnw_i,
    input  logic                    select_i,
    output logic                    ack_o,
    output logic                    rnw_o,
    output logic [C_OPB_AWIDTH-3:0] off_o,
    output logic [0:3]              be_o,
    output logic [31:0]             data_o
);
    state_e                  state_q;
    logic                    ack_q, rnw_q;
    logic [C_OPB_AWIDTH-3:0] off_q;
    logic [0:3]              be_q;
    logic [31:0]             data_q;
    logic [C_OPB_AWIDTH-1:0] word;
    logic                    hit, unused_lsb;
    assign word = abus_i - C_BASEADDR[C_OPB_AWIDTH-1:0];
    assign hit = select_i && abus_i >= C_BASEADDR[C_OPB_AWIDTH-1:0]
                 && abus_i <= C_HIGHADDR[C_OPB_AWIDTH-1:0];
    assign unused_lsb = ^word[1:0];
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
            rnw_q   <= 1'b0;
            off_q   <= '0;
            be_q    <= '0;
            data_q  <= '0;
        end else begin
            case (state_q)
                IDLE: if (hit) begin
                    state_q <= ACK;
                    ack_q   <= 1'b1;
                    rnw_q   <= rnw_i;
                    off_q   <= word[C_OPB_AWIDTH-1:2];
                    be_q    <= be_i;
                    data_q  <= data_i;
                end
                ACK: begin
                    state_q <= HOLD;
                    ack_q   <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign ack_o  = ack_q;
    assign rnw_o  = rnw_q;
    assign off_o  = off_q;
    assign be_o   = be_q;
    assign data_o = data_q;
endmodule

// File: rtl/opb_register_bank_ppc2simulink.sv
// opb_register_bank_ppc2simulink: N_REGS byte-writable shadow registers over OPB,
// committed to the user side either per write (AUTO) or all at once via CTRL.COMMIT.
module opb_register_bank_ppc2simulink
    import opb_regbank_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR   = 32'h010B0000,
    parameter logic [31:0] C_HIGHADDR   = 32'h010B00FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter              C_FAMILY     = "virtex5",
    parameter int          N_REGS       = 8
) (
    input  logic                  OPB_Clk,
    input  logic                  OPB_Rst,
    input  logic [0:31]           OPB_ABus,
    input  logic [0:3]            OPB_BE,
    input  logic [0:31]           OPB_DBus,
    input  logic                  OPB_RNW,
    input  logic                  OPB_select,
    input  logic                  OPB_seqAddr,
    output logic [0:31]           Sl_DBus,
    output logic                  Sl_errAck,
    output logic                  Sl_retry,
    output logic                  Sl_toutSup,
    output logic                  Sl_xferAck,
    output logic [N_REGS*32-1:0]  user_data_out,
    output logic [N_REGS-1:0]     user_wr_strobe,
    output logic                  user_commit_pulse
);
    localparam int OW   = C_OPB_AWIDTH - 2;
    localparam int CTRL = ctrl_offset(N_REGS);
    logic          ack, rnw;
    logic [OW-1:0] off;
    logic [0:3]    be;
    logic [31:0]   wdata, rdata, mask;
    logic [31:0]   shadow_q [N_REGS];
    logic [31:0]   shadow_d [N_REGS];
    logic [31:0]   out_q [N_REGS];
    logic [N_REGS-1:0] strobe_q;
    logic          auto_q, commit_q, wr, is_ctrl, ctrl_wr, do_commit, unused_seq;
    opb_slave_ack_fsm #(
        .C_BASEADDR  (C_BASEADDR),
        .C_HIGHADDR  (C_HIGHADDR),
        .C_OPB_AWIDTH(C_OPB_AWIDTH)
    ) u_fsm (
        .clk_i   (OPB_Clk),
        .rst_i   (OPB_Rst),
        .abus_i  (OPB_ABus),
        .be_i    (OPB_BE),
        .data_i  (OPB_DBus),
        .rnw_i   (OPB_RNW),
        .select_i(OPB_select),
        .ack_o   (ack),
        .rnw_o   (rnw),
        .off_o   (off),
        .be_o    (be),
        .data_o  (wdata)
    );
    assign unused_seq = OPB_seqAddr;
    assign mask       = lane_mask(be);
    assign wr         = ack && !rnw;
    assign is_ctrl    = off == OW'(CTRL);
    assign ctrl_wr    = wr && is_ctrl && be[3];
    assign do_commit  = ctrl_wr && wdata[CTRL_COMMIT];
    always_comb begin
        rdata = '0;
        rdata[CTRL_AUTO] = is_ctrl && auto_q;
        for (int k = 0; k < N_REGS; k++) begin
            shadow_d[k] = (shadow_q[k] & ~mask) | (wdata & mask);
            if (off == OW'(k)) rdata = shadow_q[k];
        end
    end
    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            auto_q   <= 1'b0;
            commit_q <= 1'b0;
            strobe_q <= '0;
            for (int k = 0; k < N_REGS; k++) begin
                shadow_q[k] <= '0;
                out_q[k]    <= '0;
            end
        end else begin
            commit_q <= do_commit;
            strobe_q <= '0;
            if (ctrl_wr) auto_q <= wdata[CTRL_AUTO];
            for (int k = 0; k < N_REGS; k++) begin
                if (do_commit) out_q[k] <= shadow_q[k];
                if (wr && off == OW'(k)) begin
                    shadow_q[k] <= shadow_d[k];
                    strobe_q[k] <= 1'b1;
                    if (auto_q) out_q[k] <= shadow_d[k];
                end
            end
        end
    end
    for (genvar k = 0; k < N_REGS; k++) begin : g_out
        assign user_data_out[32*k +: 32] = out_q[k];
    end
    // Reset blanks every bus/user pulse immediately, including an ack already in flight.
    assign Sl_xferAck        = ack && !OPB_Rst;
    assign Sl_DBus           = (Sl_xferAck && rnw) ? rdata : '0;
    assign user_wr_strobe    = OPB_Rst ? '0 : strobe_q;
    assign user_commit_pulse = commit_q && !OPB_Rst;
    assign Sl_errAck         = 1'b0;
    assign Sl_retry          = 1'b0;
    assign Sl_toutSup        = 1'b0;
endmodule
